// File: rtl/fpcvt_pkg.sv
// -----------------------------------------------------------------------------
// fpcvt_pkg
// Shared definitions for the fixed-point to small-float converter.
//   RND_HALF_UP / RND_TRUNC : encodings of the per-sample rounding mode bit
//   calc_emax()             : largest exponent needed for a given input and
//                             significand width
// -----------------------------------------------------------------------------
package fpcvt_pkg;

    localparam logic RND_HALF_UP = 1'b0;
    localparam logic RND_TRUNC   = 1'b1;

    // The input magnitude has DW-1 usable bits; a significand of MW bits
    // therefore needs shifts of 0..DW-1-MW.
    function automatic int calc_emax(input int dw, input int mw);
        return dw - 1 - mw;
    endfunction

endpackage

// File: rtl/fpcvt_lod.sv
// -----------------------------------------------------------------------------
// fpcvt_lod
// Combinational leading-one detector.
//   vec_i   [N-1:0]  : vector to scan
//   pos_o   [PW-1:0] : index of the most significant set bit (0 when none)
//   found_o          : at least one bit of vec_i is set
// -----------------------------------------------------------------------------
module fpcvt_lod #(
    parameter int N  = 12,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [PW-1:0] pos_o,
    output logic          found_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pos_o   = '0;
        found_o = 1'b0;
        // Ascending scan: the highest set bit is the last one to win.
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                pos_o   = PW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// fpcvt_pipe
// Three-stage converter from a DW-bit two's-complement sample to
// sign / exponent / significand form (magnitude = out_f * 2^out_e).
//   S1: magnitude   S2: leading-one extraction   S3: rounding + saturation
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : input handshake; in_data sample, in_rnd mode
//   out_valid/out_ready        : output handshake
//   out_s, out_e, out_f        : sign, exponent, significand
//   out_sat                    : result was clamped to the largest value
//   sat_cnt                    : saturating count of transferred clamped results
// The whole pipe moves on a single advance enable, so a downstream stall
// freezes every stage and the input side together.
// -----------------------------------------------------------------------------
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int DW = 13,
    parameter int MW = 5,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat,
    output logic [15:0]   sat_cnt
);

    localparam int EMAX = calc_emax(DW, MW);
    localparam int LW   = DW - 1;
    localparam int PW   = (LW > 1) ? $clog2(LW) : 1;

    if (EMAX > (2 ** EW) - 1 || MW >= DW - 1) begin : g_param_check
        $error("fpcvt_pipe: unsupported DW/MW/EW combination");
    end

    localparam logic [EW-1:0] EMAX_E = EW'(EMAX);
    localparam logic [MW-1:0] F_ONES = '1;
    localparam logic [MW-1:0] F_MSB  = MW'(1) << (MW - 1);

    logic advance;

    // Stage 1 registers
    logic          s1_valid_q;
    logic          s1_s_q;
    logic [DW-1:0] s1_mag_q;
    logic          s1_rnd_q;
    logic [DW-1:0] s1_mag_d;

    // Stage 2 registers
    logic          s2_valid_q;
    logic          s2_s_q;
    logic [EW-1:0] s2_e_q, s2_e_d;
    logic [MW-1:0] s2_f_q, s2_f_d;
    logic          s2_rbit_q, s2_rbit_d;
    logic          s2_sat_q, s2_sat_d;
    logic          s2_rnd_q;

    // Stage 3 next-state
    logic [EW-1:0] s3_e_d;
    logic [MW-1:0] s3_f_d;
    logic          s3_sat_d;

    logic [PW-1:0] lod_pos;
    logic          lod_found;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: magnitude at full DW width; the most negative input maps to
    // 2^(DW-1), which is the only value with mag[DW-1] set.
    assign s1_mag_d = in_data[DW-1] ? (~in_data + DW'(1)) : in_data;

    // S2: leading-one detection over the DW-1 low magnitude bits.
    fpcvt_lod #(
        .N (LW),
        .PW(PW)
    ) u_lod (
        .vec_i  (s1_mag_q[DW-2:0]),
        .pos_o  (lod_pos),
        .found_o(lod_found)
    );

    always_comb begin
        int            sh;
        logic [DW-1:0] rsh;
        sh        = int'(lod_pos) - MW + 1;
        rsh       = '0;
        s2_e_d    = '0;
        s2_f_d    = s1_mag_q[MW-1:0];
        s2_rbit_d = 1'b0;
        s2_sat_d  = 1'b0;
        if (s1_mag_q[DW-1]) begin
            s2_e_d   = EMAX_E;
            s2_f_d   = F_ONES;
            s2_sat_d = 1'b1;
        end else if (lod_found && int'(lod_pos) >= MW) begin
            // Keep the MW bits starting at the leading one; the next bit
            // below them decides rounding.
            rsh       = s1_mag_q >> (sh - 1);
            s2_e_d    = EW'(sh);
            s2_f_d    = MW'(s1_mag_q >> sh);
            s2_rbit_d = rsh[0];
        end
    end

    // S3: round-half-up on the first dropped bit, carrying into the exponent
    // when the significand overflows, and clamping at the top exponent.
    always_comb begin
        s3_e_d   = s2_e_q;
        s3_f_d   = s2_f_q;
        s3_sat_d = s2_sat_q;
        if (s2_rnd_q == RND_HALF_UP && s2_rbit_q && !s2_sat_q) begin
            if (s2_f_q != F_ONES) begin
                s3_f_d = s2_f_q + MW'(1);
            end else if (s2_e_q < EMAX_E) begin
                s3_f_d = F_MSB;
                s3_e_d = s2_e_q + EW'(1);
            end else begin
                s3_sat_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_mag_q   <= '0;
            s1_rnd_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_s_q     <= 1'b0;
            s2_e_q     <= '0;
            s2_f_q     <= '0;
            s2_rbit_q  <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_rnd_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_s      <= 1'b0;
            out_e      <= '0;
            out_f      <= '0;
            out_sat    <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s1_s_q     <= in_data[DW-1];
            s1_mag_q   <= s1_mag_d;
            s1_rnd_q   <= in_rnd;
            s2_valid_q <= s1_valid_q;
            s2_s_q     <= s1_s_q;
            s2_e_q     <= s2_e_d;
            s2_f_q     <= s2_f_d;
            s2_rbit_q  <= s2_rbit_d;
            s2_sat_q   <= s2_sat_d;
            s2_rnd_q   <= s1_rnd_q;
            out_valid  <= s2_valid_q;
            out_s      <= s2_s_q;
            out_e      <= s3_e_d;
            out_f      <= s3_f_d;
            out_sat    <= s3_sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpcvt_pipe
// Self-checking bench for fpcvt_pipe at DW=13, MW=5, EW=3. Directed vectors
// use hand-derived constants; random streams use an arithmetic reference
// model. A background monitor records every output transfer (sampled on the
// falling edge) and counts outputs that change while stalled.
// -----------------------------------------------------------------------------
module tb_fpcvt_pipe;
    import fpcvt_pkg::*;

    localparam int DW   = 13;
    localparam int MW   = 5;
    localparam int EW   = 3;
    localparam int EMAX = DW - 1 - MW;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
        logic          sat;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_rnd;
    logic          out_valid;
    logic          out_ready;
    logic          out_s;
    logic [EW-1:0] out_e;
    logic [MW-1:0] out_f;
    logic          out_sat;
    logic [15:0]   sat_cnt;

    fpcvt_pipe #(.DW(DW), .MW(MW), .EW(EW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_rnd   (in_rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_e    (out_e),
        .out_f    (out_f),
        .out_sat  (out_sat),
        .sat_cnt  (sat_cnt)
    );

    int   errors = 0;
    int   checks = 0;
    int   stable_err = 0;
    int   sat_exp = 0;
    bit   rand_ready = 1'b0;
    res_t obs_q[$];
    res_t cur, prev;
    bit   prev_hold = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_ready driver: held high unless a random stall pattern is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: record transfers, flag any change of a stalled output.
    always @(negedge clk) begin
        cur = '{out_s, out_e, out_f, out_sat};
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!out_valid || cur !== prev)) stable_err++;
            if (out_valid && out_ready) obs_q.push_back(cur);
            prev_hold = out_valid && !out_ready;
            prev      = cur;
        end
    end

    // Reference model from the conversion rules, using integer arithmetic.
    function automatic res_t ref_model(input logic [DW-1:0] d, input logic rnd);
        int   v, mag, e, f, r;
        res_t o;
        v   = d[DW-1] ? int'(d) - (1 << DW) : int'(d);
        mag = (v < 0) ? -v : v;
        o.s = d[DW-1];
        if (mag >= (1 << (DW - 1))) begin
            o.e = EW'(EMAX); o.f = '1; o.sat = 1'b1;
            return o;
        end
        e = 0;
        while ((mag >> e) >= (1 << MW)) e++;
        f = mag >> e;
        r = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
        o.sat = 1'b0;
        if (rnd == RND_HALF_UP && r == 1) begin
            f++;
            if (f == (1 << MW)) begin
                if (e < EMAX) begin
                    f = 1 << (MW - 1);
                    e++;
                end else begin
                    f = (1 << MW) - 1;
                    o.sat = 1'b1;
                end
            end
        end
        o.e = EW'(e);
        o.f = MW'(f);
        return o;
    endfunction

    // Present one sample and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [DW-1:0] d, input logic rnd);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = rnd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: data=%h not accepted within 200 cycles", d);
        end
    endtask

    // Wait until n outputs have been recorded, then one more edge so the
    // last transfer has updated sat_cnt.
    task automatic wait_obs(input int n);
        for (int i = 0; i < 500 && obs_q.size() < n; i++) @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL wait_outputs: got %0d outputs, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_rnd   = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_s, out_e, out_f, out_sat} !== '0 || sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b s=%b e=%0d f=%0d sat=%b cnt=%0d, required all 0",
                     out_valid, out_s, out_e, out_f, out_sat, sat_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_latency();
        int k;
        res_t exp;
        obs_q.delete();
        send('0, RND_HALF_UP);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL latency: out_valid after %0d cycles, required 3", k);
        end
        wait_obs(1);
        exp = '{1'b0, 3'd0, 5'd0, 1'b0};
        checks++;
        if (obs_q.size() > 0 && obs_q[0] !== exp) begin
            errors++;
            $display("FAIL zero_input: got %h, required %h", obs_q[0], exp);
        end
    endtask

    task automatic test_round_trunc_back_to_back();
        res_t exp[3];
        exp[0] = '{1'b0, 3'd4, 5'd26, 1'b0};
        exp[1] = '{1'b0, 3'd3, 5'd16, 1'b0};
        exp[2] = '{1'b0, 3'd2, 5'd31, 1'b0};
        obs_q.delete();
        send(13'd422, RND_HALF_UP);
        send(13'd127, RND_HALF_UP);
        send(13'd127, RND_TRUNC);
        wait_obs(3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL round_trunc[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        res_t exp[2];
        exp[0] = '{1'b0, 3'd7, 5'd31, 1'b1};
        exp[1] = '{1'b1, 3'd7, 5'd31, 1'b1};
        obs_q.delete();
        send(13'h0FFF, RND_HALF_UP);
        send(13'h1000, 1'($urandom_range(0, 1)));
        wait_obs(2);
        sat_exp += 2;
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
            end
        end
        checks++;
        if (sat_cnt !== 16'(sat_exp)) begin
            errors++;
            $display("FAIL sat_cnt_after_sat: got %0d, required %0d", sat_cnt, sat_exp);
        end
    endtask

    task automatic test_negative();
        res_t exp;
        exp = '{1'b1, 3'd4, 5'd26, 1'b0};
        obs_q.delete();
        send(13'h1E5A, RND_HALF_UP);
        wait_obs(1);
        checks++;
        if (obs_q.size() > 0 && obs_q[0] !== exp) begin
            errors++;
            $display("FAIL negative_422: got %h, required %h", obs_q[0], exp);
        end
    endtask

    task automatic test_random_stall();
        res_t          exp_q[$];
        logic [DW-1:0] d;
        logic          r;
        obs_q.delete();
        stable_err = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 13'h1000;
                1:       d = 13'h0FFF;
                2:       d = DW'($urandom_range(0, 63));
                default: d = DW'($urandom);
            endcase
            r = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_model(d, r));
            send(d, r);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_obs(20);
        rand_ready = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].sat) sat_exp++;
        for (int i = 0; i < 20 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_stream[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL stall_stability: %0d output changes while stalled, required 0", stable_err);
        end
        checks++;
        if (sat_cnt !== 16'(sat_exp)) begin
            errors++;
            $display("FAIL sat_cnt_random: got %0d, required %0d", sat_cnt, sat_exp);
        end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] d;
        logic          r;
        res_t          exp;
        send(13'h1000, RND_HALF_UP);
        send(13'd422, RND_HALF_UP);
        send(13'd127, RND_TRUNC);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: out_valid=%b sat_cnt=%0d in_ready=%b, required 0/0/1",
                     out_valid, sat_cnt, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        sat_exp = 0;
        @(posedge clk);
        #1;
        d = DW'($urandom);
        r = 1'($urandom_range(0, 1));
        exp = ref_model(d, r);
        send(d, r);
        wait_obs(1);
        checks++;
        if (obs_q.size() > 0 && obs_q[0] !== exp) begin
            errors++;
            $display("FAIL first_after_reset: got %h, required %h (data=%h rnd=%b)", obs_q[0], exp, d, r);
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_round_trunc_back_to_back();
        test_saturation();
        test_negative();
        test_random_stall();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
